// File: rtl/us_meas_sequencer.sv
// us_meas_sequencer: ultrasonic ranging FSM - transmit burst, blanked echo capture, BCD distance latch
module us_meas_sequencer #(
    parameter int BURST_CYC   = 8,
    parameter int BLANK_CM    = 20,
    parameter int MAX_CM      = 400,
    parameter int MEAS_PERIOD = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_40k,
    input  logic        tick_17k,
    input  logic        start,
    input  logic        auto_run,
    input  logic        echo_in,
    output logic        burst_en,
    output logic        busy,
    output logic [11:0] dist_bcd,
    output logic        dist_valid,
    output logic        out_of_range
);
    localparam int BW = $clog2(BURST_CYC + 1);
    localparam int PW = $clog2(MEAS_PERIOD + 1);
    localparam logic [BW-1:0] L_BURST_LAST = BW'(BURST_CYC - 1);
    localparam logic [PW-1:0] L_PERIOD     = PW'(MEAS_PERIOD);
    localparam logic [9:0]    L_BLANK      = 10'(BLANK_CM);
    localparam logic [9:0]    L_MAX        = 10'(MAX_CM);
    localparam logic [9:0]    L_SAT        = 10'd999;
    typedef enum logic [1:0] {S_IDLE, S_BURST, S_LISTEN, S_WAIT} state_t;
    state_t          r_state;
    logic            r_echo_s1, r_echo_s2, r_echo_prev;
    logic [11:0]     r_bcd;
    logic [9:0]      r_cm_bin;
    logic [BW-1:0]   r_burst_cnt;
    logic [PW-1:0]   r_period_cnt;
    logic            w_echo_rise, w_cm_step, w_period_step, w_launch;
    logic [11:0]     w_bcd_inc;
    assign w_echo_rise   = r_echo_s2 & ~r_echo_prev;
    assign w_cm_step     = tick_17k && (r_cm_bin != L_SAT);
    assign w_period_step = tick_17k && (r_state != S_IDLE) && (r_period_cnt != L_PERIOD);
    assign w_launch      = ((r_state == S_IDLE) && (start || auto_run)) ||
                           ((r_state == S_WAIT) && (r_period_cnt == L_PERIOD) && auto_run);
    assign w_bcd_inc[3:0]  = (r_bcd[3:0] == 4'd9) ? 4'd0 : r_bcd[3:0] + 4'd1;
    assign w_bcd_inc[7:4]  = (r_bcd[3:0] != 4'd9) ? r_bcd[7:4] :
                             (r_bcd[7:4] == 4'd9) ? 4'd0 : r_bcd[7:4] + 4'd1;
    assign w_bcd_inc[11:8] = (r_bcd[7:0] != 8'h99) ? r_bcd[11:8] : r_bcd[11:8] + 4'd1;
    // two-flop synchronizer for the comparator pin plus a history flop for rise detection
    always_ff @(posedge clk)
        if (reset) {r_echo_s1, r_echo_s2, r_echo_prev} <= 3'b000;
        else       {r_echo_s1, r_echo_s2, r_echo_prev} <= {echo_in, r_echo_s1, r_echo_s2};
    // measurement FSM with its counters; accept beats timeout beats tick increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            burst_en     <= 1'b0;
            busy         <= 1'b0;
            dist_bcd     <= 12'h000;
            dist_valid   <= 1'b0;
            out_of_range <= 1'b0;
            r_bcd        <= 12'h000;
            r_cm_bin     <= 10'd0;
            r_burst_cnt  <= '0;
            r_period_cnt <= '0;
        end else begin
            dist_valid <= 1'b0;
            if (w_period_step) r_period_cnt <= r_period_cnt + 1'b1;
            if (w_launch) begin
                r_state      <= S_BURST;
                burst_en     <= 1'b1;
                busy         <= 1'b1;
                r_bcd        <= 12'h000;
                r_cm_bin     <= 10'd0;
                r_burst_cnt  <= '0;
                r_period_cnt <= '0;
            end else begin
                case (r_state)
                    S_BURST: begin
                        if (w_cm_step) begin
                            r_cm_bin <= r_cm_bin + 10'd1;
                            r_bcd    <= w_bcd_inc;
                        end
                        if (tick_40k) r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (tick_40k && (r_burst_cnt == L_BURST_LAST)) begin
                            r_state  <= S_LISTEN;
                            burst_en <= 1'b0;
                        end
                    end
                    S_LISTEN: begin
                        if (w_echo_rise && (r_cm_bin >= L_BLANK)) begin
                            dist_bcd     <= r_bcd;
                            out_of_range <= 1'b0;
                            dist_valid   <= 1'b1;
                            r_state      <= S_WAIT;
                        end else if (r_cm_bin == L_MAX) begin
                            dist_bcd     <= 12'h000;
                            out_of_range <= 1'b1;
                            dist_valid   <= 1'b1;
                            r_state      <= S_WAIT;
                        end else if (w_cm_step) begin
                            r_cm_bin <= r_cm_bin + 10'd1;
                            r_bcd    <= w_bcd_inc;
                        end
                    end
                    S_WAIT: begin
                        if (r_period_cnt == L_PERIOD) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_us_meas_sequencer.sv
// tb_us_meas_sequencer: directed and randomized measurements scored against a history-scan model
module tb_us_meas_sequencer;
    localparam int TMAX        = 70000;
    localparam int BURST_CYC   = 8;
    localparam int BLANK_CM    = 20;
    localparam int MAX_CM      = 400;
    localparam int MEAS_PERIOD = 500;
    logic clk = 1'b0, reset = 1'b1, tick_40k = 1'b0, tick_17k = 1'b0;
    logic start = 1'b0, auto_run = 1'b0, echo_in = 1'b0;
    logic burst_en, busy, dist_valid, out_of_range;
    logic [11:0] dist_bcd;
    us_meas_sequencer dut (
        .clk(clk), .reset(reset), .tick_40k(tick_40k), .tick_17k(tick_17k),
        .start(start), .auto_run(auto_run), .echo_in(echo_in),
        .burst_en(burst_en), .busy(busy), .dist_bcd(dist_bcd),
        .dist_valid(dist_valid), .out_of_range(out_of_range)
    );
    always #5 clk = ~clk;
    bit h17[TMAX];
    bit h40[TMAX];
    bit hecho[TMAX];
    int pre17[TMAX];
    int e = 0, nvec = 0, nfail = 0, nval = 0, v_edge = 0;
    int last_rise = 0, last_fall = 0, last_idle = 0, n40_obs = 0, n40_fall = 0;
    int entry = 0, nxt = 0;
    logic [11:0] v_bcd = 12'h000;
    logic v_oor = 1'b0, pbe = 1'b0, pbusy = 1'b0, pval = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        if (e + 1 >= TMAX) begin
            $display("FAIL history: edge budget exhausted at %0d", e);
            $fatal(1, "edge budget exhausted");
        end
        tick_17k = ((e + 1) % 4 == 0);
        tick_40k = ((e + 1) % 2 == 1);
        h17[e+1] = tick_17k;
        h40[e+1] = tick_40k;
        hecho[e+1] = echo_in;
        @(posedge clk);
        #1;
        e++;
        pre17[e] = pre17[e-1] + (h17[e] ? 1 : 0);
        if (dist_valid === 1'b1) begin
            nval++;
            v_edge = e;
            v_bcd = dist_bcd;
            v_oor = out_of_range;
        end
        chk("valid_single_clk", {31'b0, dist_valid & pval}, 32'd0);
        if (pbe === 1'b1 && h40[e]) n40_obs++;
        if (burst_en === 1'b1 && pbe !== 1'b1) begin
            last_rise = e;
            n40_obs = 0;
        end
        if (burst_en !== 1'b1 && pbe === 1'b1) begin
            last_fall = e;
            n40_fall = n40_obs;
        end
        if (busy !== 1'b1 && pbusy === 1'b1) last_idle = e;
        pbe = burst_en;
        pbusy = busy;
        pval = dist_valid;
    endtask

    task automatic wait_cnt(input int k);
        for (int i = 0; i < 4000 && pre17[e] - pre17[entry] < k; i++) tick();
        chk("wait_count", {31'b0, pre17[e] - pre17[entry] >= k}, 32'd1);
    endtask

    task automatic echo_at(input int k, input int d);
        wait_cnt(k);
        repeat (d) tick();
        echo_in = 1'b1;
        repeat (4) tick();
        echo_in = 1'b0;
        tick();
    endtask

    // scans the recorded pin/tick history from burst entry and applies the measurement rules
    task automatic model(input int en, output int a_edge, output int val, output bit oor,
                         output int b_end, output int m_end);
        int cnt = 0, n40 = 0;
        bit lis = 1'b0;
        a_edge = -1; val = 0; oor = 1'b0; b_end = -1; m_end = -1;
        for (int x = en + 1; x <= e; x++) begin
            if (m_end < 0 && pre17[x] - pre17[en] == MEAS_PERIOD) m_end = x + 1;
            if (a_edge < 0) begin
                if (!lis) begin
                    if (h17[x] && cnt < 999) cnt++;
                    if (h40[x]) n40++;
                    if (n40 == BURST_CYC) begin
                        lis = 1'b1;
                        b_end = x;
                    end
                end else if (hecho[x-2] && !hecho[x-3] && cnt >= BLANK_CM) begin
                    a_edge = x;
                    val = cnt;
                end else if (cnt == MAX_CM) begin
                    a_edge = x;
                    oor = 1'b1;
                end else if (h17[x] && cnt < 999) cnt++;
            end
        end
    endtask

    task automatic measure(input int k1, input int d1, input int k2, input int d2, input bit pulse,
                           input bit pokes, input logic [11:0] want, input bit want_oor, input bit lit);
        int a, val, be, me, n0, fin;
        bit oor;
        if (pulse) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            entry = e;
        end else entry = nxt;
        n0 = nval;
        chk("burst_start", last_rise, entry);
        if (k1 >= 0) echo_at(k1, d1);
        if (pokes) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (k2 >= 0) echo_at(k2, d2);
        for (int i = 0; i < 4000 && !(auto_run ? last_rise > entry : last_idle > entry); i++) tick();
        fin = auto_run ? last_rise : last_idle;
        chk("meas_done", {31'b0, fin > entry}, 32'd1);
        model(entry, a, val, oor, be, me);
        chk("burst_end", last_fall, be);
        chk("burst_len", n40_fall, BURST_CYC);
        chk("valid_count", nval - n0, 1);
        chk("valid_edge", v_edge, a);
        chk("dist_bcd", v_bcd, oor ? 12'h000 : to_bcd(val));
        chk("out_of_range", v_oor, oor);
        if (lit) begin
            chk("dist_directed", v_bcd, want);
            chk("oor_directed", v_oor, want_oor);
        end
        chk("meas_end", fin, me);
        chk("period_ticks", pre17[fin] - pre17[entry], MEAS_PERIOD);
        nxt = me;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_burst_en", burst_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dist_bcd", dist_bcd, 12'h000);
        chk("rst_dist_valid", dist_valid, 0);
        chk("rst_oor", out_of_range, 0);
        reset = 1'b0;
        repeat (2) tick();
        chk("idle_busy", busy, 0);
        measure(123, 0, -1, 0, 1, 0, 12'h123, 0, 1);
        measure(15, 0, 57, 0, 1, 0, 12'h057, 0, 1);
        measure(-1, 0, -1, 0, 1, 0, 12'h000, 1, 1);
        measure(200, 0, -1, 0, 1, 0, 12'h200, 0, 1);
        measure(77, 1, -1, 0, 1, 0, 12'h077, 0, 1);
        measure(20, 0, -1, 0, 1, 0, 12'h020, 0, 1);
        measure(19, 0, 30, 0, 1, 0, 12'h030, 0, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        entry = e;
        wait_cnt(150);
        chk("hold_dist_bcd", dist_bcd, 12'h030);
        chk("listen_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("midrst_burst_en", burst_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dist_bcd", dist_bcd, 12'h000);
        chk("midrst_dist_valid", dist_valid, 0);
        chk("midrst_oor", out_of_range, 0);
        reset = 1'b0;
        auto_run = 1'b1;
        tick();
        chk("rst_release_burst", burst_en, 1);
        chk("rst_release_rise", last_rise, e);
        nxt = e;
        measure(2, 0, 88, 0, 0, 1, 12'h088, 0, 1);
        measure(64, 0, 300, 0, 0, 1, 12'h064, 0, 1);
        auto_run = 1'b0;
        measure(int'($urandom_range(480, 1)), int'($urandom_range(3, 0)), -1, 0, 0, 0, 12'h000, 0, 0);
        for (int r = 0; r < 4; r++) begin
            int k1, k2;
            k1 = int'($urandom_range(480, 1));
            k2 = ($urandom_range(1, 0) == 1) ? k1 + int'($urandom_range(60, 5)) : -1;
            if (k2 > 490) k2 = 490;
            measure(k1, int'($urandom_range(3, 0)), k2, int'($urandom_range(3, 0)), 1, 0, 12'h000, 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
